// File: rtl/lsu_mmio_hs.sv
// lsu_mmio_hs: load/store unit over data memory, output registers and switches.
// DMEM accesses that cross a word boundary are split into two memory beats.
module lsu_mmio_hs #(
  parameter int DMEM_AW = 9,
  parameter int NUM_OUT = 4,
  parameter int SW_W    = 18
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [31:0]            i_req_addr,
  input  logic [1:0]             i_req_size,
  input  logic                   i_req_unsigned,
  input  logic [31:0]            i_req_wdata,
  output logic                   o_rsp_valid,
  output logic [31:0]            o_rsp_rdata,
  output logic                   o_rsp_err,
  input  logic [SW_W-1:0]        i_sw,
  output logic [NUM_OUT*32-1:0]  o_out
);
  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1, RESP
  } state_t;

  typedef enum logic [1:0] {
    R_DMEM, R_OUT, R_SW
  } region_t;

  localparam int DW = 1 << DMEM_AW;
  localparam int TS = DMEM_AW + 2;

  state_t  state_q, state_d;
  region_t rgn_q, rgn_d, dec_rgn;

  logic we_q, we_d, uns_q, uns_d;
  logic spl_q, spl_d, err_q, err_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [DMEM_AW-1:0] widx_q, widx_d;
  logic [3:0] kidx_q, kidx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d, mmio_q, mmio_d;
  logic [SW_W-1:0] sw1_q, sw2_q;
  logic [31:0] out_q [NUM_OUT];
  logic [31:0] out_d [NUM_OUT];

  logic accept, in_dmem, in_out, in_sw;
  logic alig, dec_err, dec_spl;
  logic [1:0] nbm1;
  logic [32:0] last;

  assign o_req_ready = (state_q == IDLE) | (state_q == RESP);
  assign accept = i_req_valid & o_req_ready;

  always_comb begin
    nbm1 = 2'd0;
    unique case (i_req_size)
      2'd1: nbm1 = 2'd1;
      2'd2: nbm1 = 2'd3;
      default: nbm1 = 2'd0;
    endcase
    last = {1'b0, i_req_addr} + 33'(nbm1);
    in_dmem = (i_req_addr >> TS) == 32'd0;
    in_out = (i_req_addr[31:16] == 16'h1000)
           & ({28'd0, i_req_addr[15:12]} < 32'(NUM_OUT));
    in_sw = i_req_addr[31:12] == 20'h10010;
    alig = ~((i_req_size == 2'd1) & i_req_addr[0])
         & ~((i_req_size == 2'd2) & (|i_req_addr[1:0]));
    dec_spl = in_dmem
            & (((i_req_size == 2'd1) & (i_req_addr[1:0] == 2'd3))
            | ((i_req_size == 2'd2) & (|i_req_addr[1:0])));
    // last byte must stay inside DMEM; MMIO must be naturally aligned
    dec_err = (i_req_size == 2'd3)
            | ~(in_dmem | in_out | in_sw)
            | (in_dmem & ((last >> TS) != 33'd0))
            | (~in_dmem & ~alig)
            | (in_sw & i_req_we);
    dec_rgn = in_dmem ? R_DMEM : (in_sw ? R_SW : R_OUT);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_req_valid) state_d = dec_err ? RESP : BEAT0;
      BEAT0: state_d = spl_q ? BEAT1 : RESP;
      BEAT1: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (i_req_valid) state_d = dec_err ? RESP : BEAT0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    uns_d   = uns_q;
    spl_d   = spl_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    widx_d  = widx_q;
    kidx_d  = kidx_q;
    wdata_d = wdata_q;
    rgn_d   = rgn_q;
    if (accept) begin
      we_d    = i_req_we;
      uns_d   = i_req_unsigned;
      spl_d   = dec_spl;
      err_d   = dec_err;
      size_d  = i_req_size;
      off_d   = i_req_addr[1:0];
      widx_d  = i_req_addr[TS-1:2];
      kidx_d  = i_req_addr[15:12];
      wdata_d = i_req_wdata;
      rgn_d   = dec_rgn;
    end
  end

  logic [3:0] sz_be;
  logic [7:0] be8;
  logic [63:0] wd64;

  always_comb begin
    sz_be = 4'hf;
    unique case (size_q)
      2'd0: sz_be = 4'h1;
      2'd1: sz_be = 4'h3;
      default: sz_be = 4'hf;
    endcase
    be8 = {4'd0, sz_be} << off_q;
    wd64 = {32'd0, wdata_q} << {off_q, 3'b000};
  end

  logic [31:0] mem [DW];
  logic [31:0] mem_rd_q;
  logic [DMEM_AW-1:0] mem_idx;
  logic [3:0] mem_be;
  logic [31:0] mem_wd;
  logic mem_we;

  always_comb begin
    mem_idx = widx_q;
    mem_be  = be8[3:0];
    mem_wd  = wd64[31:0];
    if (state_q == BEAT1) begin
      mem_idx = widx_q + DMEM_AW'(1);
      mem_be  = be8[7:4];
      mem_wd  = wd64[63:32];
    end
    mem_we = we_q & (rgn_q == R_DMEM)
           & ((state_q == BEAT0) | (state_q == BEAT1));
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
    mem_rd_q <= mem[mem_idx];
  end

  logic [31:0] mmio_rd;
  logic out_wr;

  assign out_wr = (state_q == BEAT0) & we_q & (rgn_q == R_OUT);

  always_comb begin
    mmio_rd = 32'(sw2_q);
    if (rgn_q == R_OUT) begin
      mmio_rd = 32'd0;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (kidx_q == 4'(k)) mmio_rd = out_q[k];
      end
    end
    mmio_d = (state_q == BEAT0) ? mmio_rd : mmio_q;
    lo_d = (state_q == BEAT1) ? mem_rd_q : lo_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_d[k] = out_q[k];
      if (out_wr && kidx_q == 4'(k)) begin
        for (int b = 0; b < 4; b++) begin
          if (be8[b]) out_d[k][8*b +: 8] = wd64[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    o_out = '0;
    for (int k = 0; k < NUM_OUT; k++) o_out[32*k +: 32] = out_q[k];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      rgn_q   <= R_DMEM;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      spl_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      widx_q  <= '0;
      kidx_q  <= 4'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      mmio_q  <= 32'd0;
      sw1_q   <= '0;
      sw2_q   <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      rgn_q   <= rgn_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      spl_q   <= spl_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
      widx_q  <= widx_d;
      kidx_q  <= kidx_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      mmio_q  <= mmio_d;
      sw1_q   <= i_sw;
      sw2_q   <= sw1_q;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= out_d[k];
    end
  end

  // beat-1 word sits in mem_rd_q; beat-0 word in lo_q when split
  logic [31:0] w0, lw, ext;

  always_comb begin
    w0 = mmio_q;
    if (rgn_q == R_DMEM) w0 = spl_q ? lo_q : mem_rd_q;
    lw = 32'({mem_rd_q, w0} >> {off_q, 3'b000});
    ext = lw;
    unique case (size_q)
      2'd0: ext = {{24{lw[7] & ~uns_q}}, lw[7:0]};
      2'd1: ext = {{16{lw[15] & ~uns_q}}, lw[15:0]};
      default: ext = lw;
    endcase
  end

  assign o_rsp_valid = state_q == RESP;
  assign o_rsp_err = o_rsp_valid & err_q;
  assign o_rsp_rdata = (o_rsp_valid & ~err_q & ~we_q) ? ext : 32'd0;

endmodule

// File: tb/tb_lsu_mmio_hs.sv
// tb_lsu_mmio_hs: directed plan steps plus randomized traffic checked
// against a byte-array reference model of the address map.
module tb_lsu_mmio_hs;
  localparam int AW = 9;
  localparam int NOUT = 4;
  localparam int SW_W = 18;
  localparam int DBYTES = 4 << AW;

  logic i_clk, i_reset;
  logic i_req_valid, o_req_ready;
  logic i_req_we, i_req_unsigned;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [1:0] i_req_size;
  logic o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic [SW_W-1:0] i_sw;
  logic [NOUT*32-1:0] o_out;

  lsu_mmio_hs #(
    .DMEM_AW(AW),
    .NUM_OUT(NOUT),
    .SW_W(SW_W)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_we(i_req_we),
    .i_req_addr(i_req_addr),
    .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err),
    .i_sw(i_sw),
    .o_out(o_out)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [DBYTES];
  logic [31:0] out_m [NOUT];
  logic [SW_W-1:0] sw_m;

  logic [31:0] obs_rd;
  logic obs_err;
  int obs_lat;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < NOUT; k++) check(tag, o_out[32*k +: 32], out_m[k]);
  endtask

  // Reference: expected error, load data and response latency.
  task automatic model(input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] wd, output logic e,
                       output logic [31:0] rd, output int lat);
    int n, k, o, base;
    logic [31:0] v, sw32;
    n = 1 << sz;
    e = 1'b0;
    v = 32'd0;
    lat = 2;
    sw32 = 32'(sw_m);
    if (sz == 2'd3) begin
      e = 1'b1;
    end else if (a < 32'(DBYTES)) begin
      base = int'(a);
      if (base + n > DBYTES) e = 1'b1;
      else begin
        if ((base % 4) + n > 4) lat = 3;
        for (int i = 0; i < n; i++) begin
          if (we) mem_m[base+i] = wd[8*i +: 8];
          else v[8*i +: 8] = mem_m[base+i];
        end
      end
    end else if (a >= 32'h1000_0000 && a < 32'h1000_0000 + 32'(NOUT*4096)) begin
      k = int'((a - 32'h1000_0000) >> 12);
      o = int'(a % 4);
      if (o % n != 0) e = 1'b1;
      else begin
        for (int i = 0; i < n; i++) begin
          if (we) out_m[k][8*(o+i) +: 8] = wd[8*i +: 8];
          else v[8*i +: 8] = out_m[k][8*(o+i) +: 8];
        end
      end
    end else if (a[31:12] == 20'h10010) begin
      o = int'(a % 4);
      if (we || (o % n != 0)) e = 1'b1;
      else for (int i = 0; i < n; i++) v[8*i +: 8] = sw32[8*(o+i) +: 8];
    end else begin
      e = 1'b1;
    end
    if (e) lat = 1;
    if (!we && !e && !un && n == 1 && v[7]) v[31:8] = 24'hFFFFFF;
    if (!we && !e && !un && n == 2 && v[15]) v[31:16] = 16'hFFFF;
    rd = (we || e) ? 32'd0 : v;
  endtask

  // Issue at a negedge; returns at the negedge of the response cycle.
  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic un,
                        input logic [31:0] wd);
    logic e;
    logic [31:0] rd;
    int lat, got;
    model(we, a, sz, un, wd, e, rd, lat);
    check("req_ready", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1;
    i_req_we = we;
    i_req_addr = a;
    i_req_size = sz;
    i_req_unsigned = un;
    i_req_wdata = wd;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_we = 1'($urandom);
    i_req_addr = $urandom;
    i_req_size = 2'($urandom);
    i_req_unsigned = 1'($urandom);
    i_req_wdata = $urandom;
    got = 0;
    for (int c = 1; c <= 6 && got == 0; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid) got = c;
    end
    obs_lat = got;
    obs_rd = o_rsp_rdata;
    obs_err = o_rsp_err;
    check("rsp_latency", 32'(got), 32'(lat));
    if (got != 0) begin
      check("rsp_rdata", o_rsp_rdata, rd);
      check("rsp_err", {31'd0, o_rsp_err}, {31'd0, e});
    end
  endtask

  logic [31:0] ra, rw;
  logic [1:0] rs;
  int r;

  initial begin
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    i_req_we = 1'b0;
    i_req_addr = 32'd0;
    i_req_size = 2'd0;
    i_req_unsigned = 1'b0;
    i_req_wdata = 32'd0;
    i_sw = '0;
    sw_m = '0;
    for (int i = 0; i < DBYTES; i++) mem_m[i] = 8'd0;
    for (int k = 0; k < NOUT; k++) out_m[k] = 32'd0;
    #2 i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_ready", {31'd0, o_req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("reset_rdata", o_rsp_rdata, 32'd0);
    check("reset_err", {31'd0, o_rsp_err}, 32'd0);
    check_outs("reset_out");
    i_reset = 1'b1;
    @(negedge i_clk);

    for (int w = 0; w < DBYTES / 4; w++) do_req(1'b1, 32'(w * 4), 2'd2, 1'b0, 32'd0);

    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    check("plan_st_lat", 32'(obs_lat), 32'd2);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    check("plan_ld_word", obs_rd, 32'hDEADBEEF);
    check("plan_ld_lat", 32'(obs_lat), 32'd2);

    do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h80);
    do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'd0);
    check("plan_lb_signed", obs_rd, 32'hFFFFFF80);
    do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'd0);
    check("plan_lb_unsigned", obs_rd, 32'h00000080);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    check("plan_merged_word", obs_rd, 32'h80ADBEEF);

    do_req(1'b1, 32'h21, 2'd2, 1'b0, 32'h11223344);
    check("plan_split_lat", 32'(obs_lat), 32'd3);
    do_req(1'b0, 32'h20, 2'd2, 1'b0, 32'd0);
    check("plan_split_lo", obs_rd, 32'h22334400);
    do_req(1'b0, 32'h24, 2'd2, 1'b0, 32'd0);
    check("plan_split_hi", obs_rd, 32'h00000011);
    do_req(1'b0, 32'h23, 2'd1, 1'b1, 32'd0);
    check("plan_split_half", obs_rd, 32'h00001122);

    do_req(1'b1, 32'h1000_1002, 2'd1, 1'b0, 32'hABCD);
    check("plan_out1_half", o_out[63:32], 32'hABCD0000);
    do_req(1'b1, 32'h1000_1001, 2'd2, 1'b0, 32'h12345678);
    check("plan_mis_err", {31'd0, obs_err}, 32'd1);
    check("plan_out1_kept", o_out[63:32], 32'hABCD0000);
    check_outs("plan_outs");

    i_sw = 18'h25A5A;
    sw_m = 18'h25A5A;
    repeat (2) @(negedge i_clk);
    do_req(1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'd0);
    check("plan_sw_word", obs_rd, 32'h00025A5A);
    do_req(1'b1, 32'h1001_0000, 2'd2, 1'b0, 32'h1);
    check("plan_sw_store_err", {31'd0, obs_err}, 32'd1);

    do_req(1'b0, 32'h2000_0000, 2'd2, 1'b0, 32'd0);
    check("plan_unmapped_err", {31'd0, obs_err}, 32'd1);
    check("plan_err_lat", 32'(obs_lat), 32'd1);
    do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'd0);
    check("plan_size3_err", {31'd0, obs_err}, 32'd1);
    check("plan_size3_rdata", obs_rd, 32'd0);
    do_req(1'b0, 32'(DBYTES - 2), 2'd2, 1'b0, 32'd0);
    check("plan_top_err", {31'd0, obs_err}, 32'd1);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50) ra = 32'($urandom_range(0, DBYTES - 1));
      else if (r < 58) ra = 32'(DBYTES) - 32'($urandom_range(1, 8));
      else if (r < 78) ra = 32'h1000_0000 + 32'($urandom_range(0, 5) << 12)
                          + 32'($urandom_range(0, 3));
      else if (r < 88) ra = 32'h1001_0000 + 32'($urandom_range(0, 3));
      else ra = $urandom;
      rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rw = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        i_sw = SW_W'($urandom);
        sw_m = i_sw;
        repeat (3) @(negedge i_clk);
      end
      if ($urandom_range(0, 7) == 0) @(negedge i_clk);
      do_req(1'($urandom), ra, rs, 1'($urandom), rw);
      check_outs("rand_outs");
    end

    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_addr = 32'h33;
    i_req_size = 2'd2;
    i_req_unsigned = 1'b0;
    i_req_wdata = 32'hA1B2C3D4;
    check("abort_ready", {31'd0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    mem_m[32'h33] = 8'hD4;
    for (int k = 0; k < NOUT; k++) out_m[k] = 32'd0;
    #1;
    check("abort_ready_rst", {31'd0, o_req_ready}, 32'd1);
    check("abort_rsp", {31'd0, o_rsp_valid}, 32'd0);
    repeat (2) begin
      @(negedge i_clk);
      check("abort_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    end
    i_reset = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("post_rst_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    end
    check_outs("post_rst_out");
    do_req(1'b0, 32'h30, 2'd2, 1'b0, 32'd0);
    do_req(1'b0, 32'h34, 2'd2, 1'b0, 32'd0);
    do_req(1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mmio_hs.md
# lsu_mmio_hs

Parametrised load/store unit for the multicycle core. It serves a valid/ready request port and a single-cycle response pulse, and decodes addresses into three regions: data memory, a configurable bank of memory-mapped output registers, and a synchronised switch input. It supports byte, half and word accesses with byte-lane writes and sign/zero-extended loads. Accesses that cross a word boundary are split into two memory beats. Unmapped or illegal accesses return an error instead of being silently dropped.

## Interface
- DMEM_AW, 9, log2 of data-memory depth in 32-bit words (2 KiB default)
- NUM_OUT, 4, number of 32-bit output registers (1..16)
- SW_W, 18, switch input width (1..32)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid & ready at a rising edge
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  32  byte address
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  zero-extend loads when 1
- i_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- o_rsp_valid  out  1  one-cycle response pulse, for both loads and stores
- o_rsp_rdata  out  32  load data, valid with o_rsp_valid; 0 for stores and errors
- o_rsp_err  out  1  error flag, valid with o_rsp_valid
- i_sw  in  SW_W  asynchronous switch inputs
- o_out  out  NUM_OUT*32  output registers; register k occupies [32k+31:32k]

## Operation
- Address map:
  - DMEM: 0x0000_0000 .. 4*2^DMEM_AW-1.
  - OUT[k]: 0x1000_0000 + k*0x1000, window 0x1000 bytes, k < NUM_OUT; only byte offsets 0..3 within the window are meaningful.
  - SW: 0x1001_0000 .. 0x1001_0FFF, read-only.
  - All other addresses are unmapped.
- Errors. o_rsp_err=1 with no side effects for any of the following:
  - size 11
  - unmapped address
  - store to SW
  - misaligned MMIO access (any region other than DMEM)
  - DMEM access whose last byte falls beyond the DMEM top
- DMEM is byte-lane enabled, with synchronous read and synchronous write. Contents are not reset.
- Split access: a DMEM half at offset 3, or a word at offset 1..3, crosses a word boundary.
  - Beat 0 covers word A = addr[DMEM_AW+1:2].
  - Beat 1 covers word A+1.
  - Load bytes are merged little-endian.
- Stores to OUT[k] update only the addressed byte lanes.
- Loads:
  - OUT[k] loads return the current register value, lane-shifted and extended.
  - SW loads return the 2-flop synchronised i_sw, zero-extended to 32 bits, then lane-selected.
- Load extension: byte/half results are sign-extended from bit 7/15 unless i_req_unsigned=1; word loads are passed through unchanged.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE -> BEAT0 on acceptance. Errors go IDLE -> RESP directly.
  - BEAT0 -> BEAT1 if the access is split, else -> RESP.
  - BEAT1 -> RESP.
  - RESP -> BEAT0 (or RESP on an error request) if a new request is accepted; otherwise -> IDLE.
- o_req_ready = 1 only in IDLE and RESP.
- Request fields are captured at acceptance. Input changes after acceptance have no effect.

## Timing
- Reset (async assert): state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_out all 0, switch synchroniser 0.
- Reset asserted mid-operation aborts the access with no response. A beat-0 DMEM write already committed by a split store remains in memory.
- Request accepted at edge T:
  - Aligned or MMIO access: the write or read occurs at edge T+1, and o_rsp_valid is high for the cycle after T+1.
  - Split access: beats complete at edges T+1 and T+2, and o_rsp_valid is high for the cycle after T+2.
  - Error: o_rsp_valid is high for the cycle after T.
- o_out reflects a store from the cycle after the write edge (T+1).
- Back-to-back: a request accepted at the RESP-cycle edge gives one aligned access every 2 cycles.
- SW latency: 2 cycles from an i_sw change to load visibility.
- No response back-pressure: the requester must accept o_rsp_valid in the cycle it is asserted.

## Test plan
- Reset, then store word 0xDEADBEEF to 0x10 and load word from 0x10 -> rsp at T+2 each, rdata=0xDEADBEEF, err=0; o_out all 0 after reset.
- Store byte 0x80 to 0x13; load signed byte and unsigned byte from 0x13 -> 0xFFFF_FF80 and 0x0000_0080; word at 0x10 reads 0x80ADBEEF.
- Store word 0x11223344 to 0x21 (split) -> rsp at T+3; load word 0x20 -> 0x22334400 (low byte previously 0); load word 0x24 -> 0x00000011.
- Store half 0xABCD to 0x1000_1002 -> o_out[63:32]=0xABCD0000; word store to 0x1000_1001 -> err=1, o_out unchanged.
- Drive i_sw=0x2_5A5A, wait 2 cycles, load word 0x1001_0000 -> 0x0002_5A5A; store to 0x1001_0000 -> err=1.
- Load from 0x2000_0000 and a request with size=11 -> err=1, rdata=0, rsp at T+1. Assert reset during BEAT1 of a split store -> no rsp; o_req_ready=1 after reset.
